// File: rtl/mul_exp_norm_pipe.sv
// mul_exp_norm_pipe: 2-stage exponent adjust/classify pipeline; define MUL_EXP_SAT_EN to saturate the exponent on ovf/unf
module mul_exp_norm_pipe #(
  parameter int EXP_W  = 8,
  parameter int LOPD_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_un_flag,
  input  logic              i_ov_flag,
  input  logic              i_zero_flag,
  input  logic [LOPD_W-1:0] i_one_pos,
  input  logic [EXP_W-1:0]  i_data_exp,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [EXP_W-1:0]  o_exp_adjust,
  output logic              o_exp_ovf,
  output logic              o_exp_unf
);
  localparam int SW = EXP_W + 2;
  localparam logic [SW-1:0] MAX_EXP = {2'b00, {EXP_W{1'b1}}};
  logic             adv, s1_valid, s1_zero, ovf_d, unf_d;
  logic [SW-1:0]    s1_sum, sum_d, exp_x, pos_x;
  logic [EXP_W-1:0] adj_d;
  assign adv     = ~o_valid | i_ready;
  assign o_ready = adv;
  // Sum is two's complement at EXP_W+2 bits so both +1 carry and negative results survive
  always_comb begin
    exp_x = {2'b00, i_data_exp};
    pos_x = {{(SW-LOPD_W){1'b0}}, i_one_pos};
    sum_d = i_ov_flag ? exp_x + SW'(1) : i_un_flag ? exp_x : exp_x - pos_x;
  end
  always_comb begin
    ovf_d = ~s1_zero & ~s1_sum[SW-1] & (s1_sum >= MAX_EXP);
    unf_d = ~s1_zero & (s1_sum[SW-1] | (s1_sum == '0));
`ifdef MUL_EXP_SAT_EN
    adj_d = s1_zero ? '0 : ovf_d ? '1 : unf_d ? '0 : s1_sum[EXP_W-1:0];
`else
    adj_d = s1_zero ? '0 : s1_sum[EXP_W-1:0];
`endif
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid     <= 1'b0;
      s1_sum       <= '0;
      s1_zero      <= 1'b0;
      o_valid      <= 1'b0;
      o_exp_adjust <= '0;
      o_exp_ovf    <= 1'b0;
      o_exp_unf    <= 1'b0;
    end else if (adv) begin
      s1_valid     <= i_valid & o_ready;
      s1_sum       <= sum_d;
      s1_zero      <= i_zero_flag;
      o_valid      <= s1_valid;
      o_exp_adjust <= adj_d;
      o_exp_ovf    <= ovf_d;
      o_exp_unf    <= unf_d;
    end
  end
endmodule

// File: tb/tb_mul_exp_norm_pipe.sv
// tb_mul_exp_norm_pipe: directed and randomized checks of mul_exp_norm_pipe against a queue-based arithmetic model
module tb_mul_exp_norm_pipe;
  logic       i_clk = 1'b0, i_rst_n = 1'b0, i_valid = 1'b0, i_ready = 1'b1;
  logic       i_un_flag = 1'b0, i_ov_flag = 1'b0, i_zero_flag = 1'b0;
  logic [7:0] i_one_pos = '0, i_data_exp = '0;
  logic       o_ready, o_valid, o_exp_ovf, o_exp_unf;
  logic [7:0] o_exp_adjust;
  int         cmp_cnt = 0, err_cnt = 0, out_cnt = 0;
  logic [9:0] exp_q[$];

  mul_exp_norm_pipe #(.EXP_W(8), .LOPD_W(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_un_flag(i_un_flag), .i_ov_flag(i_ov_flag), .i_zero_flag(i_zero_flag),
    .i_one_pos(i_one_pos), .i_data_exp(i_data_exp), .o_valid(o_valid),
    .i_ready(i_ready), .o_exp_adjust(o_exp_adjust), .o_exp_ovf(o_exp_ovf),
    .o_exp_unf(o_exp_unf));

  always #5 i_clk = ~i_clk;

  // Expected {adjusted exponent, ovf, unf} from plain integer arithmetic
  function automatic logic [9:0] model(input int e, input int p, input bit z, input bit ov, input bit un);
    int s;
    bit o, u;
    logic [31:0] sv;
    logic [7:0] a;
    s  = ov ? e + 1 : un ? e : e - p;
    o  = !z && s >= 255;
    u  = !z && s <= 0;
    sv = s;
`ifdef MUL_EXP_SAT_EN
    a = z ? 8'h00 : o ? 8'hFF : u ? 8'h00 : sv[7:0];
`else
    a = z ? 8'h00 : sv[7:0];
`endif
    return {a, o, u};
  endfunction

  // Scoreboard: transfers are decided at the next rising edge, sampled mid-cycle
  always @(negedge i_clk) begin
    if (!i_rst_n) exp_q.delete();
    else begin
      if (o_valid && i_ready) begin
        cmp_cnt++;
        out_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++;
          $display("FAIL stream: unexpected result adj=%h ovf=%b unf=%b with nothing outstanding", o_exp_adjust, o_exp_ovf, o_exp_unf);
        end else begin
          if ({o_exp_adjust, o_exp_ovf, o_exp_unf} !== exp_q[0]) begin
            err_cnt++;
            $display("FAIL stream: got adj=%h ovf=%b unf=%b, expected adj=%h ovf=%b unf=%b",
                     o_exp_adjust, o_exp_ovf, o_exp_unf, exp_q[0][9:2], exp_q[0][1], exp_q[0][0]);
          end
          void'(exp_q.pop_front());
        end
      end
      if (i_valid && o_ready)
        exp_q.push_back(model(int'(i_data_exp), int'(i_one_pos), i_zero_flag, i_ov_flag, i_un_flag));
    end
  end

  task automatic send(input logic [7:0] e, input logic [7:0] p, input bit z, input bit ov, input bit un);
    bit rdy;
    i_valid = 1'b1; i_data_exp = e; i_one_pos = p;
    i_zero_flag = z; i_ov_flag = ov; i_un_flag = un;
    for (int k = 0; k < 64; k++) begin
      @(negedge i_clk);
      rdy = o_ready;
      @(posedge i_clk);
      #1;
      if (rdy) return;
    end
    i_valid = 1'b0;
    cmp_cnt++;
    err_cnt++;
    $display("FAIL send_timeout: o_ready=%b, required 1 within 64 cycles", o_ready);
  endtask

  task automatic run_one(input string name, input logic [7:0] e, input logic [7:0] p, input bit z, input bit ov,
                         input bit un, input logic [7:0] adj_sat, input logic [7:0] adj_raw, input bit o, input bit u);
    logic [7:0] adj;
`ifdef MUL_EXP_SAT_EN
    adj = adj_sat;
`else
    adj = adj_raw;
`endif
    send(e, p, z, ov, un);
    i_valid = 1'b0;
    for (int k = 0; k < 20 && !o_valid; k++) begin
      @(posedge i_clk);
      #1;
    end
    cmp_cnt++;
    if (o_valid !== 1'b1 || {o_exp_adjust, o_exp_ovf, o_exp_unf} !== {adj, o, u}) begin
      err_cnt++;
      $display("FAIL %s: got valid=%b adj=%h ovf=%b unf=%b, expected valid=1 adj=%h ovf=%b unf=%b",
               name, o_valid, o_exp_adjust, o_exp_ovf, o_exp_unf, adj, o, u);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    cmp_cnt++;
    if ({o_valid, o_ready, o_exp_adjust, o_exp_ovf, o_exp_unf} !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL reset_state: valid=%b ready=%b adj=%h ovf=%b unf=%b, expected 0 1 00 0 0",
               o_valid, o_ready, o_exp_adjust, o_exp_ovf, o_exp_unf);
    end
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_latency();
    send(8'h80, 8'd3, 0, 0, 0);
    i_valid = 1'b0;
    cmp_cnt++;
    if (o_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL latency_1cyc: o_valid=%b, expected 0 one cycle after accept", o_valid);
    end
    @(posedge i_clk);
    #1;
    cmp_cnt++;
    if ({o_valid, o_exp_adjust, o_exp_ovf, o_exp_unf} !== {1'b1, 8'h7D, 1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL latency_2cyc: valid=%b adj=%h ovf=%b unf=%b, expected 1 7d 0 0",
               o_valid, o_exp_adjust, o_exp_ovf, o_exp_unf);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_boundaries();
    run_one("ovf_fe",     8'hFE, 8'd0, 0, 1, 0, 8'hFF, 8'hFF, 1, 0);
    run_one("ovf_ff",     8'hFF, 8'd0, 0, 1, 0, 8'hFF, 8'h00, 1, 0);
    run_one("unf_neg",    8'h02, 8'd5, 0, 0, 0, 8'h00, 8'hFD, 0, 1);
    run_one("un_pass",    8'h05, 8'd7, 0, 0, 1, 8'h05, 8'h05, 0, 0);
    run_one("zero_prio",  8'hFF, 8'd0, 1, 1, 0, 8'h00, 8'h00, 0, 0);
    run_one("ov_over_un", 8'h10, 8'd0, 0, 1, 1, 8'h11, 8'h11, 0, 0);
    run_one("unf_exact0", 8'h03, 8'd3, 0, 0, 0, 8'h00, 8'h00, 0, 1);
    run_one("max_normal", 8'hFE, 8'd0, 0, 0, 0, 8'hFE, 8'hFE, 0, 0);
  endtask

  task automatic test_back_to_back();
    int start;
    bit seen;
    i_ready = 1'b1;
    start = out_cnt;
    seen = 1'b0;
    fork
      begin
        send(8'h40, 8'd0, 0, 0, 0);
        send(8'h41, 8'd0, 0, 0, 0);
        send(8'h42, 8'd0, 0, 0, 0);
        i_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 20 && !seen; k++) begin
          @(posedge i_clk);
          #1;
          seen = o_valid;
        end
        cmp_cnt++;
        if (!seen) begin
          err_cnt++;
          $display("FAIL bp_first_valid: o_valid=%b, required 1 within 20 cycles", o_valid);
        end
        i_ready = 1'b0;
        repeat (3) begin
          @(negedge i_clk);
          cmp_cnt++;
          if ({o_ready, o_valid, o_exp_adjust} !== {1'b0, 1'b1, 8'h40}) begin
            err_cnt++;
            $display("FAIL bp_hold: ready=%b valid=%b adj=%h, expected 0 1 40", o_ready, o_valid, o_exp_adjust);
          end
          @(posedge i_clk);
          #1;
        end
        i_ready = 1'b1;
      end
    join
    repeat (4) @(posedge i_clk);
    #1;
    cmp_cnt++;
    if (out_cnt - start !== 3) begin
      err_cnt++;
      $display("FAIL bp_count: %0d results delivered, expected 3", out_cnt - start);
    end
  endtask

  task automatic test_reset_in_flight();
    i_ready = 1'b0;
    send(8'h10, 8'd0, 0, 0, 0);
    send(8'h20, 8'd0, 0, 0, 0);
    i_valid = 1'b0;
    cmp_cnt++;
    if (o_valid !== 1'b1) begin
      err_cnt++;
      $display("FAIL flight_loaded: o_valid=%b, expected 1", o_valid);
    end
    #2;
    i_rst_n = 1'b0;
    #1;
    cmp_cnt++;
    if ({o_valid, o_ready, o_exp_adjust, o_exp_ovf, o_exp_unf} !== {1'b0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL async_reset: valid=%b ready=%b adj=%h ovf=%b unf=%b, expected 0 1 00 0 0",
               o_valid, o_ready, o_exp_adjust, o_exp_ovf, o_exp_unf);
    end
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    repeat (4) begin
      @(negedge i_clk);
      cmp_cnt++;
      if (o_valid !== 1'b0) begin
        err_cnt++;
        $display("FAIL stale_after_reset: o_valid=%b adj=%h, expected valid 0", o_valid, o_exp_adjust);
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_random();
    bit done;
    logic [7:0] e;
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          if ($urandom_range(0, 3) == 0) begin
            i_valid = 1'b0;
            @(posedge i_clk);
            #1;
          end
          e = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 3) + ($urandom_range(0, 1) * 252)) : 8'($urandom);
          send(e, 8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end
        i_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          i_ready = $urandom_range(0, 3) != 0;
          @(posedge i_clk);
          #1;
        end
        i_ready = 1'b1;
      end
    join
    repeat (6) @(posedge i_clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_boundaries();
    test_back_to_back();
    test_reset_in_flight();
    test_random();
    cmp_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL drain: %0d results still outstanding, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
